// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b.
// One full-subtractor slice plus a borrow flop processes one bit per clock,
// LSB first. Operands are taken on a start handshake in IDLE. The result
// ports are a registered copy loaded only when the last bit is formed, so
// partially shifted values never show up on diff/borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // Bit counter wide enough to count 0..WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_sr_reg,   a_sr_next;
    logic [WIDTH-1:0] b_sr_reg,   b_sr_next;
    logic [WIDTH-1:0] d_sr_reg,   d_sr_next;
    logic             br_reg,     br_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [WIDTH-1:0] diff_reg,   diff_next;
    logic             borrow_reg, borrow_next;

    // Bit-slice signals for the current LSB pair.
    logic slice_x;
    logic slice_y;
    logic slice_d;
    logic slice_bo;

    // Full-subtractor slice: difference and borrow-out of x - y - borrow-in.
    always_comb begin
        slice_x  = a_sr_reg[0];
        slice_y  = b_sr_reg[0];
        slice_d  = slice_x ^ slice_y ^ br_reg;
        slice_bo = (~slice_x & slice_y) | (~(slice_x ^ slice_y) & br_reg);
    end

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_next  = state_reg;
        a_sr_next   = a_sr_reg;
        b_sr_next   = b_sr_reg;
        d_sr_next   = d_sr_reg;
        br_next     = br_reg;
        cnt_next    = cnt_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sr_next  = a;
                    b_sr_next  = b;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                br_next   = slice_bo;
                d_sr_next = {slice_d, d_sr_reg[WIDTH-1:1]};
                a_sr_next = {1'b0, a_sr_reg[WIDTH-1:1]};
                b_sr_next = {1'b0, b_sr_reg[WIDTH-1:1]};
                cnt_next  = cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_LAST) begin
                    // Last bit: publish the completed result as we enter DONE.
                    state_next  = DONE;
                    diff_next   = {slice_d, d_sr_reg[WIDTH-1:1]};
                    borrow_next = slice_bo;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            d_sr_reg   <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sr_reg   <= a_sr_next;
            b_sr_reg   <= b_sr_next;
            d_sr_reg   <= d_sr_next;
            br_reg     <= br_next;
            cnt_reg    <= cnt_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
        end
    end

    // Status is decoded straight from the state so reset clears it immediately.
    assign busy   = (state_reg == SHIFT) || (state_reg == DONE);
    assign done   = (state_reg == DONE);
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule
